// File: rtl/vip_uart_rx_ctrl.sv
// vip_uart_rx_ctrl: services the UART receiver ready/clear handshake and buffers bytes in a line-oriented FIFO.
// Define VIP_UART_RX_CTRL_TIMEOUT_EN to force-close an open line after `timeout` idle clocks.
module vip_uart_rx_ctrl #(
  parameter int unsigned depth    = 16,
  parameter logic [7:0]  eol_char = 8'h0A,
  parameter int unsigned timeout  = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_rx_rdy,
  input  logic [7:0]                 i_rx_data,
  output logic                       o_rx_rdy_clr,
  input  logic                       i_rd_en,
  output logic [7:0]                 o_rd_data,
  output logic                       o_rd_eol,
  output logic                       o_rd_empty,
  output logic [$clog2(depth+1)-1:0] o_line_cnt,
  output logic                       o_overflow,
  input  logic                       i_ovf_clr
);

  localparam int unsigned ptr_w = $clog2(depth);
  localparam int unsigned cnt_w = $clog2(depth + 1);
  localparam logic [ptr_w:0] depth_cnt = (ptr_w + 1)'(depth);

  typedef enum logic {
    IDLE,
    CLR
  } state_t;

  state_t             state;
  logic [7:0]         mem_data [depth];
  logic [depth-1:0]   mem_eol;
  logic [ptr_w-1:0]   wr_ptr;
  logic [ptr_w-1:0]   rd_ptr;
  logic [ptr_w-1:0]   last_ptr;
  logic [ptr_w:0]     count;
  logic [cnt_w-1:0]   line_cnt;
  logic               overflow;

  logic capture;
  logic full;
  logic accept;
  logic drop;
  logic pop;
  logic eol_in;
  logic open_line;
  logic mark;
  logic line_inc;
  logic line_dec;

  // Fullness is judged before any same-cycle pop, so a write into a full FIFO drops even while draining.
  always_comb begin
    capture   = (state == IDLE) && i_rx_rdy;
    full      = (count == depth_cnt);
    accept    = capture && !full;
    drop      = capture && full;
    pop       = i_rd_en && (count != '0);
    eol_in    = (i_rx_data == eol_char);
    last_ptr  = wr_ptr - 1'b1;
    open_line = (count != '0) && !mem_eol[last_ptr];
    line_inc  = (accept && eol_in) || mark;
    line_dec  = pop && mem_eol[rd_ptr];
  end

`ifdef VIP_UART_RX_CTRL_TIMEOUT_EN
  localparam int unsigned idle_w = $clog2(timeout + 1);
  localparam logic [idle_w-1:0] idle_max  = idle_w'(timeout);
  localparam logic [idle_w-1:0] idle_last = idle_w'(timeout - 1);

  logic [idle_w-1:0] idle_cnt;

  // Saturating at timeout guarantees a single mark per idle period.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idle_cnt <= '0;
    end else if (capture) begin
      idle_cnt <= '0;
    end else if (idle_cnt != idle_max) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // A pop that empties the FIFO removes the line being closed, so it suppresses the mark.
  always_comb begin
    mark = (idle_cnt == idle_last) && !capture && open_line && !(pop && (count == 1));
  end
`else
  logic unused_timeout;

  assign mark           = 1'b0;
  assign unused_timeout = (timeout != 0);
`endif

  always_ff @(posedge i_clk) begin
    if (accept) begin
      mem_data[wr_ptr] <= i_rx_data;
      mem_eol[wr_ptr]  <= eol_in;
    end
    if (mark) begin
      mem_eol[last_ptr] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      line_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (i_rx_rdy) state <= CLR;
        CLR:     state <= IDLE;
        default: state <= IDLE;
      endcase

      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;

      if (accept && !pop) begin
        count <= count + 1'b1;
      end else if (!accept && pop) begin
        count <= count - 1'b1;
      end

      if (line_inc && !line_dec) begin
        line_cnt <= line_cnt + 1'b1;
      end else if (!line_inc && line_dec) begin
        line_cnt <= line_cnt - 1'b1;
      end

      if (drop) begin
        overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign o_rx_rdy_clr = (state == CLR);
  assign o_rd_empty   = (count == '0);
  assign o_rd_data    = o_rd_empty ? 8'h00 : mem_data[rd_ptr];
  assign o_rd_eol     = !o_rd_empty && mem_eol[rd_ptr];
  assign o_line_cnt   = line_cnt;
  assign o_overflow   = overflow;

endmodule

// File: doc/vip_uart_rx_ctrl.md
# vip_uart_rx_ctrl

Receive-side controller for the UART verification IP. Services the `vip_uart_receiver` ready/clear handshake, stores received bytes in a line-oriented FIFO, and tells the testbench consumer how many complete lines are held. Lines close on an end-of-line character or on an idle timeout. Sits between the UART receiver VIP and the bench console/scoreboard logic.

## Interface
- `depth`, 16: FIFO entries. Power of two, ≥2.
- `eol_char`, 8'h0A: byte value that closes a line.
- `timeout`, 1024: idle clocks after the last stored byte before an open line is force-closed. Must be ≥1.
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset; one clock; reset is synchronous and active-high
- `i_rx_rdy`  in  1  receiver byte-ready (`o_rdy` of the receiver)
- `i_rx_data`  in  8  receiver byte (`o_data`)
- `o_rx_rdy_clr`  out  1  one-cycle clear pulse to receiver `i_rdy_clr`
- `i_rd_en`  in  1  pop head entry; ignored when empty
- `o_rd_data`  out  8  head byte (first-word-fall-through); 0 when empty
- `o_rd_eol`  out  1  head byte is the last byte of a line; 0 when empty
- `o_rd_empty`  out  1  FIFO empty
- `o_line_cnt`  out  $clog2(depth+1)  number of entries with eol flag set
- `o_overflow`  out  1  sticky: a byte was dropped because the FIFO was full
- `i_ovf_clr`  in  1  clears `o_overflow`

## Operation
- Handshake FSM, 2 states:
  - IDLE: if `i_rx_rdy`=1, capture `i_rx_data` (write attempt) and go to CLR.
  - CLR: `o_rx_rdy_clr`=1 for exactly this cycle, then return to IDLE unconditionally.
- `o_rx_rdy_clr` is decoded from the state register only.
- FIFO entry = {eol, data[7:0]}. A write sets eol=1 iff data==`eol_char`.
- Write when full (count==depth, evaluated before any same-cycle pop):
  - byte dropped; `o_overflow`←1; CLR still issued.
- Pop when `i_rd_en`=1 and count>0: head advances.
- `o_line_cnt`:
  - +1 on a write with eol=1 or on a timeout mark.
  - −1 on a pop of an eol=1 entry.
  - Simultaneous +1/−1 nets to 0.
- Open line: count>0 and the most recently written entry still in the FIFO has eol=0.
- Idle counter:
  - cleared on every accepted or dropped byte capture;
  - increments otherwise, saturating at `timeout`.
  - When it reaches `timeout` with an open line, set eol on entry `wr_ptr-1` (one mark per idle period); `o_line_cnt`+1.
- If a pop empties the FIFO in the same cycle as a timeout mark, the pop wins and no mark occurs.
- The consumer may pop bytes of an unfinished line. If the open line is fully drained, nothing is marked.
- `i_ovf_clr` and a new overflow in the same cycle: set wins.
- Pointers are $clog2(depth) bits and wrap modulo depth. Count has one extra bit.

## Timing
- Reset values: state IDLE, pointers/count 0, idle counter 0, `o_rx_rdy_clr`=0, `o_rd_empty`=1, `o_rd_data`=0, `o_rd_eol`=0, `o_line_cnt`=0, `o_overflow`=0.
- Reset mid-operation discards all FIFO content and lines. The receiver's pending `rdy` is serviced after reset deassertion.
- `i_rx_rdy` sampled high at edge N:
  - byte visible at head (if FIFO was empty) and `o_line_cnt` updated after edge N;
  - `o_rx_rdy_clr`=1 during cycle N+1;
  - receiver `rdy` low from N+2, when IDLE resumes.
- Pop: `i_rd_en` at edge N → next head visible after edge N.
- Timeout mark: takes effect `timeout` edges after the last capture edge.
- Minimum byte spacing handled without loss: 2 clocks.

## Configuration
- `VIP_UART_RX_CTRL_TIMEOUT_EN` defined: idle counter and timeout marking are present as described.
- Not defined: no idle counter. Lines close only on `eol_char`, and the `timeout` parameter is unused.

## Test plan
- Bytes 'A','B',0x0A each as one-cycle `i_rx_rdy` pulses, each followed by `o_rx_rdy_clr`=1 exactly one cycle later → `o_line_cnt`=1; pops read 41/0,42/0,0A/1; then `o_rd_empty`=1 and `o_line_cnt`=0.
- depth=16, 17 bytes without EOL, no pops → 16 stored; `o_overflow`=1; `i_ovf_clr` → 0. CLR pulse issued for all 17.
- Byte 'x' then 1024 idle clocks (TIMEOUT_EN) → `o_line_cnt` goes 0→1 exactly 1024 edges after capture; pop gives 78/1. Without the macro, `o_line_cnt` stays 0.
- FIFO holds one EOL entry; pop and a new EOL write in the same cycle → `o_line_cnt` stays 1.
- `i_rst` asserted with 5 bytes stored → all outputs at reset values on the next cycle; a subsequent byte is stored at index 0.
